mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit; consumes the EX/MEM pipeline register outputs (MemRead, MemWrite, size flags, unsigned_load, ALUResult address, WriteData).
- Drives a req/ack data-memory bus with byte enables and extracts/extends load data.
- Stalls the pipeline while an access is outstanding and presents load data to the MEM/WB register.
- Multi-cycle FSM with timeout counter.

---
 rtl/mem_stage_lsu.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM-stage load/store unit. It drives a req/ack data bus with byte
//            enables and lane-replicated store data, and sign/zero-extends load
//            data. It stalls the pipeline while an access is outstanding.
//            The optional MISALIGN_TRAP_EN macro traps misaligned accesses
//            instead of issuing them.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             one_byte,
  input  logic             two_byte,
  input  logic             four_bytes,
  input  logic             unsigned_load,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] WriteData,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             stall,
  output logic [WIDTH-1:0] ReadData,
  output logic             load_valid,
  output logic             bus_err
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             misaligned
`endif
);

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_REQ  = 2'd1;
  localparam logic [1:0] C_ST_DONE = 2'd2;

  localparam logic [1:0] C_SZ_BYTE = 2'd0;
  localparam logic [1:0] C_SZ_HALF = 2'd1;
  localparam logic [1:0] C_SZ_WORD = 2'd2;

  localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [1:0]           r_size;
  logic [1:0]           r_lane;
  logic                 r_unsigned;
  logic                 r_is_load;
  logic                 r_bus_err;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_access;
  logic [1:0]           w_size;
  logic [1:0]           w_lane;
  logic [3:0]           w_be;
  logic [WIDTH-1:0]     w_wdata;
  logic                 w_misal;
  logic [7:0]           w_rbyte;
  logic [15:0]          w_rhalf;
  logic [WIDTH-1:0]     w_load_ext;

`ifdef MISALIGN_TRAP_EN
  logic r_misal;
`endif

  assign w_access = MemRead | MemWrite;

  // Size priority: word > half > byte; no flag defaults to a word access.
  always_comb begin
    w_size = C_SZ_WORD;
    if (four_bytes)    w_size = C_SZ_WORD;
    else if (two_byte) w_size = C_SZ_HALF;
    else if (one_byte) w_size = C_SZ_BYTE;
  end

  // Effective lane drops address bits finer than the access size.
  always_comb begin
    w_lane  = 2'b00;
    w_be    = 4'b1111;
    w_wdata = WriteData;
    case (w_size)
      C_SZ_BYTE: begin
        w_lane  = ALUResult[1:0];
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      C_SZ_HALF: begin
        w_lane  = {ALUResult[1], 1'b0};
        w_be    = 4'b0011 << {ALUResult[1], 1'b0};
        w_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        w_lane  = 2'b00;
        w_be    = 4'b1111;
        w_wdata = WriteData;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    w_misal = 1'b0;
    if (w_size == C_SZ_HALF && ALUResult[0])          w_misal = 1'b1;
    if (w_size == C_SZ_WORD && ALUResult[1:0] != 2'b00) w_misal = 1'b1;
  end
  assign misaligned = r_misal;
`else
  assign w_misal = 1'b0;
`endif

  // Load extraction uses the access attributes latched at issue time.
  always_comb begin
    w_rbyte    = mem_rdata[{r_lane, 3'b000} +: 8];
    w_rhalf    = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load_ext = mem_rdata;
    case (r_size)
      C_SZ_BYTE: w_load_ext = {{(WIDTH-8){~r_unsigned & w_rbyte[7]}}, w_rbyte};
      C_SZ_HALF: w_load_ext = {{(WIDTH-16){~r_unsigned & w_rhalf[15]}}, w_rhalf};
      default:   w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= C_ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE: if (w_access) w_state_nxt = w_misal ? C_ST_DONE : C_ST_REQ;
      C_ST_REQ:  if (mem_ack || r_cnt == C_CNT_LAST) w_state_nxt = C_ST_DONE;
      C_ST_DONE: w_state_nxt = C_ST_IDLE;
      default:   w_state_nxt = C_ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    stall      = 1'b0;
    load_valid = 1'b0;
    case (r_state)
      C_ST_IDLE: stall = w_access;
      C_ST_REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
      end
      C_ST_DONE: load_valid = r_is_load;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
      r_size     <= C_SZ_BYTE;
      r_lane     <= 2'b00;
      r_unsigned <= 1'b0;
      r_is_load  <= 1'b0;
      r_cnt      <= '0;
      ReadData   <= '0;
      r_bus_err  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_misal    <= 1'b0;
`endif
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (w_access) begin
            r_cnt <= '0;
            if (w_misal) begin
              r_is_load <= 1'b0;
              ReadData  <= '0;
`ifdef MISALIGN_TRAP_EN
              r_misal   <= 1'b1;
`endif
            end else begin
              mem_we     <= MemWrite;
              mem_addr   <= {ALUResult[WIDTH-1:2], 2'b00};
              mem_be     <= w_be;
              mem_wdata  <= w_wdata;
              r_size     <= w_size;
              r_lane     <= w_lane;
              r_unsigned <= unsigned_load;
              r_is_load  <= MemRead & ~MemWrite;
            end
          end
        end
        C_ST_REQ: begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (mem_ack) begin
            ReadData <= w_load_ext;
          end else if (r_cnt == C_CNT_LAST) begin
            ReadData  <= '0;
            r_bus_err <= 1'b1;
          end
        end
        C_ST_DONE: begin
          r_bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          r_misal   <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus_err = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Directed, table-driven bench for mem_stage_lsu plus hand-written
//            timeout, reset-abort and misalignment sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, one_byte, two_byte, four_bytes, unsigned_load;
  logic [31:0] ALUResult, WriteData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] ReadData;
  logic        load_valid, bus_err;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rd, wr, b1, b2, b4, uns;
    logic [31:0] addr, wdata, rdata;
    int          delay;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we, e_lv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .one_byte(one_byte), .two_byte(two_byte), .four_bytes(four_bytes),
    .unsigned_load(unsigned_load),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .ReadData(ReadData),
    .load_valid(load_valid), .bus_err(bus_err)
`ifdef MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    MemRead = 0; MemWrite = 0; one_byte = 0; two_byte = 0; four_bytes = 0;
    unsigned_load = 0; ALUResult = 0; WriteData = 0;
  endtask

  task automatic issue(input vec_t v);
    MemRead = v.rd; MemWrite = v.wr; one_byte = v.b1; two_byte = v.b2;
    four_bytes = v.b4; unsigned_load = v.uns; ALUResult = v.addr; WriteData = v.wdata;
  endtask

  task automatic do_access(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    issue(v);
    #1;
    chk({t, " idle_stall"}, stall, 1);
    chk({t, " idle_req"}, mem_req, 0);
    tick();
    drive_idle();
    chk({t, " req"}, mem_req, 1);
    chk({t, " stall"}, stall, 1);
    chk({t, " addr"}, mem_addr, v.e_addr);
    chk({t, " be"}, mem_be, v.e_be);
    chk({t, " wdata"}, mem_wdata, v.e_wdata);
    chk({t, " we"}, mem_we, v.e_we);
    for (int d = 0; d < v.delay; d++) begin
      tick();
      chk({t, " req_held"}, mem_req, 1);
      chk({t, " addr_held"}, mem_addr, v.e_addr);
      chk({t, " be_held"}, mem_be, v.e_be);
    end
    mem_ack = 1; mem_rdata = v.rdata;
    tick();
    mem_ack = 0; mem_rdata = 32'h5555_AAAA;
    chk({t, " done_req"}, mem_req, 0);
    chk({t, " done_stall"}, stall, 0);
    chk({t, " done_lv"}, load_valid, v.e_lv);
    chk({t, " done_err"}, bus_err, 0);
    if (v.e_lv) chk({t, " rdata"}, ReadData, v.e_rd);
    tick();
    chk({t, " idle_lv"}, load_valid, 0);
    if (v.e_lv) chk({t, " rdata_hold"}, ReadData, v.e_rd);
  endtask

  initial begin
    int   cycles;
    vec_t v;
    // rd wr b1 b2 b4 uns addr wdata rdata delay e_addr e_be e_wdata e_we e_lv e_rd
    vecs.push_back('{0,1,1,0,0,0, 32'h1003, 32'hA5, 32'h0, 0, 32'h1000, 4'b1000, 32'hA5A5A5A5, 1,0, 32'h0});
    vecs.push_back('{1,0,1,0,0,0, 32'h2002, 32'h0, 32'h00F30000, 0, 32'h2000, 4'b0100, 32'h0, 0,1, 32'hFFFFFFF3});
    vecs.push_back('{1,0,1,0,0,1, 32'h2002, 32'h0, 32'h00F30000, 1, 32'h2000, 4'b0100, 32'h0, 0,1, 32'h000000F3});
    vecs.push_back('{1,0,0,1,0,0, 32'h2002, 32'h0, 32'h80010000, 4, 32'h2000, 4'b1100, 32'h0, 0,1, 32'hFFFF8001});
    vecs.push_back('{1,0,0,1,0,1, 32'h2000, 32'h0, 32'h12348765, 0, 32'h2000, 4'b0011, 32'h0, 0,1, 32'h00008765});
    vecs.push_back('{1,0,0,0,1,0, 32'h3000, 32'h0, 32'hDEADBEEF, 2, 32'h3000, 4'b1111, 32'h0, 0,1, 32'hDEADBEEF});
    vecs.push_back('{0,1,0,1,0,0, 32'h4002, 32'h1234ABCD, 32'h0, 1, 32'h4000, 4'b1100, 32'hABCDABCD, 1,0, 32'h0});
    vecs.push_back('{0,1,0,0,1,0, 32'h5004, 32'hCAFEF00D, 32'h0, 0, 32'h5004, 4'b1111, 32'hCAFEF00D, 1,0, 32'h0});
    vecs.push_back('{1,0,0,0,0,0, 32'h6000, 32'h0, 32'h01020304, 0, 32'h6000, 4'b1111, 32'h0, 0,1, 32'h01020304});
    vecs.push_back('{1,1,1,0,0,0, 32'h7001, 32'h5A, 32'h0, 0, 32'h7000, 4'b0010, 32'h5A5A5A5A, 1,0, 32'h0});
    vecs.push_back('{1,0,1,0,1,0, 32'h8000, 32'h0, 32'hA1B2C3D4, 0, 32'h8000, 4'b1111, 32'h0, 0,1, 32'hA1B2C3D4});
    vecs.push_back('{1,0,1,1,0,0, 32'h9000, 32'h0, 32'hFFFF007F, 0, 32'h9000, 4'b0011, 32'h0, 0,1, 32'h0000007F});
    vecs.push_back('{1,0,1,0,0,0, 32'hA001, 32'h0, 32'h00008000, 0, 32'hA000, 4'b0010, 32'h0, 0,1, 32'hFFFFFF80});
    vecs.push_back('{1,0,1,0,0,0, 32'hA000, 32'h0, 32'hFFFFFF7F, 0, 32'hA000, 4'b0001, 32'h0, 0,1, 32'h0000007F});
`ifndef MISALIGN_TRAP_EN
    vecs.push_back('{1,0,0,0,1,0, 32'h3001, 32'h0, 32'h11223344, 0, 32'h3000, 4'b1111, 32'h0, 0,1, 32'h11223344});
    vecs.push_back('{1,0,0,1,0,1, 32'h2003, 32'h0, 32'hBEEF0000, 0, 32'h2000, 4'b1100, 32'h0, 0,1, 32'h0000BEEF});
`endif

    rst = 0; mem_ack = 0; mem_rdata = 0;
    drive_idle();
    tick();
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst ReadData", ReadData, 0);
    chk("rst load_valid", load_valid, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst stall", stall, 0);
    rst = 1;
    tick();

    foreach (vecs[i]) do_access(vecs[i], i);

    // Timeout: word load that is never acknowledged.
    v = '{1,0,0,0,1,0, 32'hB000, 32'h0, 32'h0, 0, 32'hB000, 4'b1111, 32'h0, 0,1, 32'h0};
    issue(v);
    tick();
    drive_idle();
    cycles = 0;
    while (mem_req === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
    chk("timeout req_cycles", cycles, 16);
    chk("timeout bus_err", bus_err, 1);
    chk("timeout ReadData", ReadData, 0);
    chk("timeout stall", stall, 0);
    tick();
    chk("timeout bus_err_pulse", bus_err, 0);
    chk("timeout idle_req", mem_req, 0);
    do_access(vecs[5], 100);

    // Reset asserted mid-request, then a stray ack after release.
    issue(vecs[5]);
    tick();
    drive_idle();
    tick();
    chk("rstreq req_before", mem_req, 1);
    #2 rst = 0;
    #1;
    chk("rstreq req_async", mem_req, 0);
    chk("rstreq ReadData", ReadData, 0);
    chk("rstreq mem_addr", mem_addr, 0);
    #2 rst = 1;
    tick();
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 0;
    chk("rstreq late_ack_req", mem_req, 0);
    chk("rstreq late_ack_lv", load_valid, 0);
    chk("rstreq late_ack_rd", ReadData, 0);
    chk("rstreq stall", stall, 0);
    tick();
    chk("rstreq idle_lv", load_valid, 0);

`ifdef MISALIGN_TRAP_EN
    v = '{1,0,0,0,1,0, 32'h3001, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0,0, 32'h0};
    issue(v);
    #1;
    chk("mis idle_stall", stall, 1);
    tick();
    drive_idle();
    chk("mis flag", misaligned, 1);
    chk("mis req", mem_req, 0);
    chk("mis lv", load_valid, 0);
    chk("mis stall", stall, 0);
    chk("mis rd", ReadData, 0);
    tick();
    chk("mis flag_pulse", misaligned, 0);
    chk("mis req_after", mem_req, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
